// File: rtl/i2c_eeprom_slave.sv
// 256-byte 24C02-style I2C EEPROM slave with filtered bus sampling,
// sequential read/write and a modelled internal write-cycle busy time.
module i2c_eeprom_slave #(
    parameter logic [6:0] DEV_ADDR   = 7'h50,
    parameter int         FILTER_LEN = 4,
    parameter int         TWR_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl_wire,
    inout  wire        sda_wire,
    output logic       busy,
    output logic [3:0] slave_state,
    output logic       wr_strobe
);

    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TWR_CYCLES + 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV_ADDR,
        ST_ACK_DEV,
        ST_WORD_ADDR,
        ST_ACK_WORD,
        ST_WR_DATA,
        ST_ACK_DATA,
        ST_RD_DATA,
        ST_RD_MACK,
        ST_WAIT_STOP
    } state_t;

    // bit 1 = SCL, bit 0 = SDA
    logic [1:0]    s1, s2, filt, filt_q;
    logic [CW-1:0] fcnt [2];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1     <= '1;
            s2     <= '1;
            filt   <= '1;
            filt_q <= '1;
            for (int i = 0; i < 2; i++) fcnt[i] <= '0;
        end else begin
            s1     <= {scl_wire, sda_wire};
            s2     <= s1;
            filt_q <= filt;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == CW'(FILTER_LEN - 1)) begin
                    filt[i] <= s2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 1'b1;
                end
            end
        end
    end

    logic sda_f, scl_rise, scl_fall, start_c, stop_c;

    assign sda_f    = filt[0];
    assign scl_rise = filt[1] & ~filt_q[1];
    assign scl_fall = ~filt[1] & filt_q[1];
    assign start_c  = filt[1] & filt_q[1] & filt_q[0] & ~filt[0];
    assign stop_c   = filt[1] & filt_q[1] & ~filt_q[0] & filt[0];

    state_t        state, state_n;
    logic [3:0]    cnt, cnt_n;
    logic [7:0]    sh, sh_n, ptr, ptr_n, tx, tx_n;
    logic [7:0]    byte_in, rd_byte;
    logic          oe, oe_n, rw, rw_n, wrote, wrote_n;
    logic          commit, twr_load;
    logic [TW-1:0] timer;
    logic [7:0]    mem [256];

    assign byte_in = {sh[6:0], sda_f};
    assign rd_byte = mem[ptr];

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        sh_n     = sh;
        ptr_n    = ptr;
        tx_n     = tx;
        oe_n     = oe;
        rw_n     = rw;
        wrote_n  = wrote;
        commit   = 1'b0;
        twr_load = 1'b0;
        if (start_c) begin
            state_n = ST_DEV_ADDR;
            cnt_n   = 4'd0;
            sh_n    = 8'h00;
            oe_n    = 1'b0;
            wrote_n = 1'b0;
        end else if (stop_c) begin
            state_n  = ST_IDLE;
            oe_n     = 1'b0;
            twr_load = wrote;
            wrote_n  = 1'b0;
        end else begin
            case (state)
                ST_DEV_ADDR: if (scl_rise) begin
                    sh_n  = byte_in;
                    cnt_n = cnt + 4'd1;
                    if (cnt == 4'd7) begin
                        rw_n    = sda_f;
                        state_n = (sh[6:0] == DEV_ADDR && !busy)
                                ? ST_ACK_DEV : ST_WAIT_STOP;
                    end
                end
                ST_WORD_ADDR: if (scl_rise) begin
                    sh_n  = byte_in;
                    cnt_n = cnt + 4'd1;
                    if (cnt == 4'd7) begin
                        ptr_n   = byte_in;
                        state_n = ST_ACK_WORD;
                    end
                end
                ST_WR_DATA: if (scl_rise) begin
                    sh_n  = byte_in;
                    cnt_n = cnt + 4'd1;
                    if (cnt == 4'd7) state_n = ST_ACK_DATA;
                end
                ST_ACK_DEV, ST_ACK_WORD, ST_ACK_DATA: if (scl_fall) begin
                    // first fall starts the ACK, second fall ends it
                    if (!oe) begin
                        oe_n = 1'b1;
                        if (state == ST_ACK_DATA) begin
                            commit  = 1'b1;
                            ptr_n   = ptr + 8'd1;
                            wrote_n = 1'b1;
                        end
                    end else begin
                        oe_n  = 1'b0;
                        cnt_n = 4'd0;
                        if (state == ST_ACK_DEV && rw) begin
                            state_n = ST_RD_DATA;
                            oe_n    = ~rd_byte[7];
                            tx_n    = {rd_byte[6:0], 1'b0};
                            cnt_n   = 4'd1;
                        end else if (state == ST_ACK_DEV) begin
                            state_n = ST_WORD_ADDR;
                        end else begin
                            state_n = ST_WR_DATA;
                        end
                    end
                end
                ST_RD_DATA: if (scl_fall) begin
                    if (cnt == 4'd8) begin
                        oe_n    = 1'b0;
                        ptr_n   = ptr + 8'd1;
                        state_n = ST_RD_MACK;
                    end else begin
                        oe_n  = ~tx[7];
                        tx_n  = {tx[6:0], 1'b0};
                        cnt_n = cnt + 4'd1;
                    end
                end
                ST_RD_MACK: if (scl_rise) begin
                    if (!sda_f) begin
                        state_n = ST_RD_DATA;
                        tx_n    = rd_byte;
                        cnt_n   = 4'd0;
                    end else begin
                        state_n = ST_WAIT_STOP;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            sh        <= 8'h00;
            ptr       <= 8'h00;
            tx        <= 8'h00;
            oe        <= 1'b0;
            rw        <= 1'b0;
            wrote     <= 1'b0;
            wr_strobe <= 1'b0;
            timer     <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            sh        <= sh_n;
            ptr       <= ptr_n;
            tx        <= tx_n;
            oe        <= oe_n;
            rw        <= rw_n;
            wrote     <= wrote_n;
            wr_strobe <= commit;
            if (twr_load)
                timer <= TW'(TWR_CYCLES);
            else if (timer != '0)
                timer <= timer - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && commit) mem[ptr] <= sh;
    end

    assign busy        = (timer != '0);
    assign slave_state = state;
    assign sda_wire    = oe ? 1'b0 : 1'bz;

endmodule
